// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and helpers for the stream demultiplexer.
package demux_pkg;
  localparam int DEMUX_MAX_N = 16;
  localparam int DEF_N = 4;
  localparam int DEF_W = 8;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_ERR_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/demux_sel_dec.sv
// demux_sel_dec: select code to one-hot channel mask plus out-of-range flag.
module demux_sel_dec
  import demux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     onehot,
  output logic             illegal
);
  for (genvar i = 0; i < N; i++) begin : g_dec
    assign onehot[i] = sel == SEL_W'(i);
  end
  assign illegal = 32'(sel) >= 32'(N);
endmodule

// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N demux with per-channel valid/ready and broadcast.
module demux_stream
  import demux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int W     = DEF_W,
  parameter int SEL_W = DEF_SEL_W,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     d_in,
  input  logic [SEL_W-1:0] d_sel,
  input  logic             d_bcast,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [N*W-1:0]   d_out,
  output logic [N-1:0]     d_out_valid,
  input  logic [N-1:0]     d_out_ready,
  output logic             d_busy,
  output logic             d_err,
  output logic [ERR_W-1:0] d_err_cnt
);
  if (N < 2 || N > DEMUX_MAX_N || SEL_W < clog2(N)) begin : g_bad_param
    $error("demux_stream: unsupported N/SEL_W combination");
  end
  logic [W-1:0] hold_data;
  logic [N-1:0] hold_mask, next_mask, onehot;
  logic         illegal, accept, bad;
  demux_sel_dec #(.N(N), .SEL_W(SEL_W)) u_dec (
    .sel    (d_sel),
    .onehot (onehot),
    .illegal(illegal)
  );
  assign d_ready = ~|(hold_mask & ~d_out_ready);
  assign accept  = d_valid & d_ready;
  assign bad     = accept & ~d_bcast & illegal;
  // a fresh accept replaces the mask outright, overriding same-cycle clears
  always_comb begin
    next_mask = hold_mask & ~d_out_ready;
    if (accept) next_mask = d_bcast ? {N{1'b1}} : (illegal ? '0 : onehot);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_mask <= '0;
      d_err     <= 1'b0;
      d_err_cnt <= '0;
    end else begin
      hold_mask <= next_mask;
      d_err     <= bad;
      if (accept && !bad) hold_data <= d_in;
      if (bad && !(&d_err_cnt)) d_err_cnt <= d_err_cnt + ERR_W'(1);
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_out
    assign d_out[i*W +: W] = hold_mask[i] ? hold_data : '0;
  end
  assign d_out_valid = hold_mask;
  assign d_busy      = |hold_mask;
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: channel-level model plus directed scenarios for demux_stream.
module tb_demux_stream;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk = 0;
  logic           rst_n;
  logic [W-1:0]   d_in;
  logic [1:0]     d_sel;
  logic           d_bcast, d_valid, d_ready, d_busy, d_err;
  logic [N*W-1:0] d_out;
  logic [N-1:0]   d_out_valid, d_out_ready;
  logic [7:0]     d_err_cnt;
  logic [W-1:0]   s3_in;
  logic [1:0]     s3_sel;
  logic           s3_valid, s3_ready, s3_busy, s3_err;
  logic [3*W-1:0] s3_out;
  logic [2:0]     s3_out_valid;
  logic [1:0]     s3_err_cnt;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  demux_stream #(.N(N), .W(W), .SEL_W(2), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_sel(d_sel), .d_bcast(d_bcast),
    .d_valid(d_valid), .d_ready(d_ready), .d_out(d_out), .d_out_valid(d_out_valid),
    .d_out_ready(d_out_ready), .d_busy(d_busy), .d_err(d_err), .d_err_cnt(d_err_cnt)
  );
  demux_stream #(.N(3), .W(W), .SEL_W(2), .ERR_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .d_in(s3_in), .d_sel(s3_sel), .d_bcast(1'b0),
    .d_valid(s3_valid), .d_ready(s3_ready), .d_out(s3_out), .d_out_valid(s3_out_valid),
    .d_out_ready(3'b111), .d_busy(s3_busy), .d_err(s3_err), .d_err_cnt(s3_err_cnt)
  );
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // Model: each channel either holds a word for its consumer or is empty.
  logic [N-1:0] mv;
  logic [W-1:0] md [N];
  logic         merr;
  int           mcnt;
  function automatic logic model_ready();
    for (int i = 0; i < N; i++) if (mv[i] && !d_out_ready[i]) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv = '0;
      for (int i = 0; i < N; i++) md[i] = '0;
      merr = 0;
      mcnt = 0;
    end else begin
      merr = 0;
      if (d_valid && model_ready()) begin
        for (int i = 0; i < N; i++) begin
          mv[i] = d_bcast || (int'(d_sel) == i);
          if (mv[i]) md[i] = d_in;
        end
        if (!d_bcast && int'(d_sel) >= N) begin
          merr = 1;
          if (mcnt < 255) mcnt++;
        end
      end else begin
        for (int i = 0; i < N; i++) if (d_out_ready[i]) mv[i] = 0;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      logic [N*W-1:0] eo;
      for (int i = 0; i < N; i++) eo[i*W +: W] = mv[i] ? md[i] : '0;
      chk("m_valid", 64'(d_out_valid), 64'(mv));
      chk("m_data", 64'(d_out), 64'(eo));
      chk("m_ready", 64'(d_ready), 64'(model_ready()));
      chk("m_busy", 64'(d_busy), 64'(|mv));
      chk("m_err", 64'(d_err), 64'(merr));
      chk("m_cnt", 64'(d_err_cnt), 64'(mcnt));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 0; d_in = 0; d_sel = 0; d_bcast = 0; d_valid = 0; d_out_ready = '1;
    s3_in = 0; s3_sel = 0; s3_valid = 0;
    repeat (2) step();
    rst_n = 1;
    at_neg();
    chk("rst_valid", 64'(d_out_valid), 0);
    chk("rst_out", 64'(d_out), 0);
    chk("rst_ready", 64'(d_ready), 1);
    chk("rst_cnt", 64'(d_err_cnt), 0);
    step();
    d_valid = 1; d_sel = 2; d_in = 8'hA5;
    step();
    d_valid = 0;
    at_neg();
    chk("t2_valid", 64'(d_out_valid), 64'b0100);
    chk("t2_ch2", 64'(d_out[23:16]), 64'hA5);
    chk("t2_other", 64'({d_out[31:24], d_out[15:0]}), 0);
    step();
    at_neg();
    chk("t2_clear", 64'(d_out_valid), 0);
    step();
    d_out_ready = 4'b1101; d_valid = 1; d_sel = 1; d_in = 8'h11;
    step();
    d_valid = 0; d_in = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t3_ready", 64'(d_ready), 0);
      chk("t3_ch1", 64'(d_out[15:8]), 64'h11);
      chk("t3_valid", 64'(d_out_valid), 64'b0010);
      step();
    end
    d_out_ready = '1;
    at_neg();
    chk("t3_accept", 64'(d_ready), 1);
    step();
    at_neg();
    chk("t3_clear", 64'(d_out_valid), 0);
    d_out_ready = 4'b0101; d_valid = 1; d_bcast = 1; d_in = 8'h3C;
    step();
    d_valid = 0; d_bcast = 0;
    at_neg();
    chk("t4_m1", 64'(d_out_valid), 64'b1111);
    chk("t4_r1", 64'(d_ready), 0);
    chk("t4_ch3", 64'(d_out[31:24]), 64'h3C);
    step();
    d_out_ready = 4'b1010;
    at_neg();
    chk("t4_m2", 64'(d_out_valid), 64'b1010);
    chk("t4_r2", 64'(d_ready), 1);
    step();
    d_out_ready = '1;
    at_neg();
    chk("t4_m3", 64'(d_out_valid), 0);
    d_valid = 1;
    for (int i = 0; i < 4; i++) begin
      d_sel = 2'(i); d_in = 8'(8'h40 + i);
      step();
      at_neg();
      chk("t6_onehot", 64'(d_out_valid), 64'(1 << i));
      chk("t6_ready", 64'(d_ready), 1);
    end
    d_valid = 0;
    step();
    for (int c = 0; c < 60; c++) begin
      d_valid = 1'($urandom_range(0, 1));
      d_bcast = ($urandom_range(0, 3) == 0);
      d_sel = 2'($urandom_range(0, 3));
      d_in = 8'($urandom);
      d_out_ready = 4'($urandom);
      step();
    end
    d_valid = 0; d_out_ready = '1; d_bcast = 0;
    step();
    s3_valid = 1; s3_sel = 3; s3_in = 8'h77;
    step();
    s3_valid = 0;
    at_neg();
    chk("t5_err", 64'(s3_err), 1);
    chk("t5_valid", 64'(s3_out_valid), 0);
    chk("t5_cnt1", 64'(s3_err_cnt), 1);
    step();
    at_neg();
    chk("t5_pulse", 64'(s3_err), 0);
    s3_valid = 1;
    repeat (4) step();
    s3_valid = 0;
    at_neg();
    chk("t5_sat", 64'(s3_err_cnt), 3);
    s3_valid = 1; s3_sel = 2; s3_in = 8'h5A;
    step();
    s3_valid = 0;
    at_neg();
    chk("t5_legal", 64'(s3_out_valid), 64'b100);
    chk("t5_data", 64'(s3_out[23:16]), 64'h5A);
    chk("t5_noerr", 64'(s3_err), 0);
    step();
    d_out_ready = 4'b1101; d_valid = 1; d_sel = 1; d_in = 8'h99;
    step();
    d_valid = 0;
    at_neg();
    chk("t1_pend", 64'(d_out_valid), 64'b0010);
    rst_n = 0;
    #1;
    chk("t1_valid", 64'(d_out_valid), 0);
    chk("t1_out", 64'(d_out), 0);
    step();
    rst_n = 1;
    d_out_ready = '1;
    at_neg();
    chk("t1_ready", 64'(d_ready), 1);
    chk("t1_after", 64'(d_out_valid), 0);
    chk("t1_cnt3", 64'(s3_err_cnt), 0);
    step();
    at_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
